// File: rtl/clk_mem_pkg.sv
// Shared constants for the divider bank and the transition-counter memory.
// Divisors are half-periods counted in bit-clock cycles.
package clk_mem_pkg;

    localparam int ADDR_W   = 4;
    localparam int NUM_CNTR = 16;
    localparam int DW       = 32;

    localparam int DIV10 = 5;
    localparam int DIV20 = 10;
    localparam int DIV40 = 20;

endpackage

// File: rtl/clk_div_stage.sv
// One divide-by-2*HALF stage: a flop-driven output that toggles every HALF enabled
// clock edges. Disabling the stage freezes both its phase count and its output.
module clk_div_stage #(
    parameter int HALF = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    output logic clk_o
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] phaseCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phaseCnt <= '0;
            clk_o    <= 1'b0;
        end else if (enb) begin
            if (phaseCnt == CW'(HALF - 1)) begin
                phaseCnt <= '0;
                clk_o    <= ~clk_o;
            end else begin
                phaseCnt <= phaseCnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_trans_mem.sv
// Symbol-rate clock dividers (clk/10, /20, /40) plus a bank of saturating
// per-flop transition counters with combinational read-back.
module clk_div_trans_mem
    import clk_mem_pkg::DIV10, clk_mem_pkg::DIV20, clk_mem_pkg::DIV40;
#(
    parameter int ADDR_W   = clk_mem_pkg::ADDR_W,
    parameter int NUM_CNTR = clk_mem_pkg::NUM_CNTR,
    parameter int DW       = clk_mem_pkg::DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_enb,
    output logic                clk10,
    output logic                clk20,
    output logic                clk40,
    input  logic [ADDR_W-1:0]   dir,
    input  logic                le,
    input  logic [DW-1:0]       dato_in,
    output logic [DW-1:0]       dato_out,
    input  logic [NUM_CNTR-1:0] inc
);

    localparam int ADDR_SPAN = 2 ** ADDR_W;

    clk_div_stage #(.HALF(DIV10)) uDiv10 (.clk(clk), .rst(rst), .enb(clk_enb), .clk_o(clk10));
    clk_div_stage #(.HALF(DIV20)) uDiv20 (.clk(clk), .rst(rst), .enb(clk_enb), .clk_o(clk20));
    clk_div_stage #(.HALF(DIV40)) uDiv40 (.clk(clk), .rst(rst), .enb(clk_enb), .clk_o(clk40));

    logic [DW-1:0]        mem [NUM_CNTR];
    logic [ADDR_SPAN-1:0] addrOk;
    logic                 dirValid;
    logic                 wrEn;

    // Address-space holes above NUM_CNTR are decoded through a lookup rather than a compare.
    always_comb begin
        addrOk = '0;
        for (int i = 0; i < ADDR_SPAN; i++) begin
            addrOk[i] = (i < NUM_CNTR);
        end
    end

    assign dirValid = addrOk[dir];
    assign wrEn     = !le && dirValid;

    // A write to a counter takes priority over its increment strobe in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNTR; i++) begin
                if (wrEn && (int'(dir) == i)) begin
                    mem[i] <= dato_in;
                end else if (inc[i] && !(&mem[i])) begin
                    mem[i] <= mem[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        dato_out = '0;
        if (le && dirValid) begin
            dato_out = mem[dir];
        end
    end

endmodule

// File: tb/tb_clk_div_trans_mem.sv
// Directed bench for clk_div_trans_mem: a behavioural model checked every negedge
// plus literal expectations for the key divider edges and counter cases.
module tb_clk_div_trans_mem;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        clk_enb = 1'b0;
    logic        le      = 1'b1;
    logic [3:0]  dir     = '0;
    logic [31:0] dato_in = '0;
    logic [15:0] inc     = '0;
    logic        clk10, clk20, clk40;
    logic [31:0] dato_out;

    int total = 0;
    int bad   = 0;
    bit chkOn = 1'b0;

    longint unsigned mMem [16];
    int              enCnt = 0;

    clk_div_trans_mem dut (
        .clk(clk), .rst(rst), .clk_enb(clk_enb),
        .clk10(clk10), .clk20(clk20), .clk40(clk40),
        .dir(dir), .le(le), .dato_in(dato_in), .dato_out(dato_out), .inc(inc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a divided clock is high during odd blocks of HALF enabled edges since reset.
    function automatic logic mDiv(input int half);
        return ((enCnt / half) % 2) == 1;
    endfunction

    function automatic logic [31:0] mRead();
        longint unsigned v;
        v = le ? mMem[dir] : 64'd0;
        return v[31:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            enCnt = 0;
            foreach (mMem[i]) mMem[i] = 0;
        end else begin
            if (clk_enb) enCnt++;
            for (int i = 0; i < 16; i++) begin
                if (!le && dir == i) mMem[i] = dato_in;
                else if (inc[i]) mMem[i] = (mMem[i] + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mMem[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chkOn) begin
            chk("model_clk10", {31'd0, clk10}, {31'd0, mDiv(5)});
            chk("model_clk20", {31'd0, clk20}, {31'd0, mDiv(10)});
            chk("model_clk40", {31'd0, clk40}, {31'd0, mDiv(20)});
            chk("model_read", dato_out, mRead());
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    initial begin
        repeat (3) step();
        chkOn = 1'b1;
        chk("rst_clk10", {31'd0, clk10}, 32'd0);
        chk("rst_read", dato_out, 32'd0);

        rst = 1'b1;
        clk_enb = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 4)  chk("clk10_before_rise", {31'd0, clk10}, 32'd0);
            if (k == 5)  chk("clk10_rise5", {31'd0, clk10}, 32'd1);
            if (k == 9)  chk("clk20_before_rise", {31'd0, clk20}, 32'd0);
            if (k == 10) begin
                chk("clk10_fall10", {31'd0, clk10}, 32'd0);
                chk("clk20_rise10", {31'd0, clk20}, 32'd1);
            end
            if (k == 19) chk("clk40_before_rise", {31'd0, clk40}, 32'd0);
            if (k == 20) chk("clk40_rise20", {31'd0, clk40}, 32'd1);
        end

        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            clk_enb = !(k >= 7 && k <= 10);
            step();
            if (k == 10) chk("clk10_frozen", {31'd0, clk10}, 32'd1);
            if (k == 13) chk("clk10_held13", {31'd0, clk10}, 32'd1);
            if (k == 14) chk("clk10_fall14", {31'd0, clk10}, 32'd0);
        end
        clk_enb = 1'b1;

        le = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dir = 4'(i); dato_in = 32'd0;
            step();
        end
        le = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dir = 4'(i); #1;
            chk("read_zero", dato_out, 32'd0);
        end

        le = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dir = 4'(i); dato_in = pat(i);
            step();
        end
        le = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dir = 4'(i); #1;
            chk("read_pattern", dato_out, pat(i));
        end

        le = 1'b0; dir = 4'd3; dato_in = 32'hFFFF_FFFE;
        step();
        le = 1'b1; inc = 16'h0008;
        repeat (3) step();
        inc = '0; #1;
        chk("saturate", dato_out, 32'hFFFF_FFFF);

        dir = 4'd7; inc = 16'h0080; #1;
        chk("read_old_during_inc", dato_out, 32'h1007_0015);
        step();
        inc = '0; #1;
        chk("inc_plus_one", dato_out, 32'h1007_0016);

        le = 1'b0; dir = 4'd6; dato_in = 32'd0;
        step();
        dir = 4'd5; dato_in = 32'h10; inc = 16'h0060; #1;
        chk("write_read_disabled", dato_out, 32'd0);
        step();
        inc = '0; le = 1'b1; #1;
        chk("write_beats_inc", dato_out, 32'h10);
        dir = 4'd6; #1;
        chk("inc_parallel", dato_out, 32'd1);

        for (int n = 0; n < 20 && clk10 !== 1'b1; n++) step();
        chk("pre_reset_clk10", {31'd0, clk10}, 32'd1);
        rst = 1'b0; #1;
        chk("midrst_clk10", {31'd0, clk10}, 32'd0);
        chk("midrst_clk20", {31'd0, clk20}, 32'd0);
        chk("midrst_clk40", {31'd0, clk40}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            dir = 4'(i); #1;
            chk("midrst_read", dato_out, 32'd0);
        end
        step();
        rst = 1'b1;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
